ysyx_23060236_trap_ctrl: RTL and testbench
==========================================

Name: ysyx_23060236_trap_ctrl

Overview:
- Trap sequencer: the initiator side of the CSR write/redirect interface.
- Accepts synchronous exceptions (ecall, illegal, misaligned), mret and timer interrupts from the pipeline, and waits for the pipeline to drain.
- Drives an ordered CSR write sequence (mepc, mcause, mstatus) onto the CSR file's write port, then issues one redirect PC to IFU over a valid/ready handshake.
- Sits beside the CSR file; replaces ad-hoc ecall/mret jump logic.

Parameters:
- RESET_PC, 32'h3000_0000, redirect target if mtvec is zero (debug safety).
- TIMER_CODE, 7, mcause code for machine timer interrupt.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- exc_valid  in  1  synchronous exception from WB (single-cycle pulse)
- exc_code  in  5  exception cause (e.g. 11 ecall-M, 2 illegal)
- exc_pc  in  32  PC of faulting instruction
- mret_valid  in  1  mret retired in WB (pulse)
- irq_timer  in  1  level timer interrupt from CLINT
- irq_pc  in  32  next PC to resume at for interrupts
- pipe_idle  in  1  no instruction in flight after WB
- mstatus_in  in  32  current mstatus
- mtvec_in  in  32  current mtvec
- mepc_in  in  32  current mepc
- mie_mtie  in  1  mie.MTIE
- csr_wen  out  1  CSR write strobe
- csr_waddr  out  12  CSR address (341/342/300)
- csr_wdata  out  32  CSR write data
- flush  out  1  kill younger instructions / stall fetch
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  IFU accepts redirect
- busy  out  1  FSM not IDLE

Behaviour:
- Reset, async: state=IDLE; all outputs 0; latched kind/cause/pc cleared.
- Requests are sampled only in IDLE. Priority: exc_valid > mret_valid > interrupt.
- interrupt = irq_timer & mie_mtie & mstatus_in[3].
- On accept, latch into registers:
  - kind: EXC, MRET or IRQ.
  - cause: exc → {0,exc_code}; IRQ → {1,TIMER_CODE}.
  - save_pc: exc_pc for EXC, irq_pc for IRQ.
- Requests arriving outside IDLE are ignored; the pipeline holds irq_timer level. Exceptions are impossible while flush=1.
- States:
  - IDLE: on accept → DRAIN.
  - DRAIN: flush=1. If pipe_idle → (MRET ? WR_STATUS : WR_EPC).
  - WR_EPC: csr_wen=1, waddr=12'h341, wdata={save_pc[31:2],2'b00} → WR_CAUSE.
  - WR_CAUSE: csr_wen=1, waddr=12'h342, wdata={cause[bit],26'b0,cause[4:0]} (bit 31 = interrupt flag) → WR_STATUS.
  - WR_STATUS: csr_wen=1, waddr=12'h300.
    - EXC/IRQ: wdata = mstatus_in with MPIE[7]=MIE[3], MIE=0, MPP[12:11]=2'b11.
    - MRET: MIE=MPIE, MPIE=1, MPP=2'b11.
    - → REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc stable. EXC/IRQ → mtvec_in base {[31:2],00} (RESET_PC if base==0); MRET → mepc_in. Stay until redirect_ready; then → IDLE.
- flush=1 in every state except IDLE. busy=(state!=IDLE).
- Outputs are registered, or decoded directly from state and latched registers; no comb path from request inputs to outputs.
- Latency: request at edge t → DRAIN at t+1. With pipe_idle already 1:
  - exception: redirect_valid at t+5;
  - mret: redirect_valid at t+3.
- csr_wen is high exactly one cycle per write state. Each CSR is written at most once per trap.
- redirect_valid, once high, stays high with redirect_pc unchanged until the handshake completes.
- pipe_idle stuck 0: remain in DRAIN indefinitely with flush=1.
- Reset mid-sequence aborts immediately. Partial CSR writes are acceptable; no redirect is issued.

Optional Feature:
- Macro YSYX_23060236_TRAP_VECTORED_EN.
- Defined: when mtvec_in[1:0]==2'b01 and kind==IRQ, redirect_pc = base + 4*cause[4:0]. Exceptions always use base.
- Undefined: mtvec_in[1:0] ignored; all traps go to base.

Test Plan:
- ecall: exc_valid=1, code=11, exc_pc=32'h8000_0104, pipe_idle=1, mstatus_in=32'h1808, mtvec_in=32'h8000_0200 → writes 341=8000_0104, 342=0000_000B, 300=0000_1880; redirect_pc=8000_0200; flush high 5 cycles.
- mret: mstatus_in=32'h1880, mepc_in=32'h8000_0108 → single write 300=0000_1888; redirect_pc=8000_0108 three cycles after accept.
- timer irq: irq_timer=1, mie_mtie=1, MIE=1, irq_pc=32'h8000_0040 → 342=8000_0007, 341=8000_0040. Repeat with MIE=0 → no accept, busy stays 0.
- Priority/backpressure: exc_valid and irq same cycle → exception taken. pipe_idle=0 for 4 cycles → DRAIN held, no csr_wen. redirect_ready=0 for 3 cycles → redirect_valid and redirect_pc stable.
- Reset asserted async in WR_CAUSE → outputs 0 immediately, state IDLE, no redirect afterwards.
- With YSYX_23060236_TRAP_VECTORED_EN and mtvec_in=32'h8000_0201, timer irq → redirect_pc=8000_021C. Same stimulus without the macro → 8000_0200.

Source files
------------

// File: rtl/ysyx_23060236_trap_ctrl.sv
// Trap sequencer: drains the pipeline, writes mepc/mcause/mstatus, then redirects IFU.
// Optional macro YSYX_23060236_TRAP_VECTORED_EN enables vectored interrupt targets.
module ysyx_23060236_trap_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h3000_0000,
    parameter logic [4:0]  TIMER_CODE = 5'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    input  logic        irq_timer,
    input  logic [31:0] irq_pc,
    input  logic        pipe_idle,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        mie_mtie,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_WR_EPC, S_WR_CAUSE, S_WR_STATUS, S_REDIRECT
    } state_e;
    typedef enum logic [1:0] {K_EXC, K_MRET, K_IRQ} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [5:0]  cause_q, cause_d;
    logic [31:0] save_pc_q, save_pc_d;
    logic [31:0] rpc_q, rpc_d;

    logic        irq_take;
    logic [31:0] tvec_base, trap_target, status_new;

    assign irq_take  = irq_timer & mie_mtie & mstatus_in[3];
    assign tvec_base = {mtvec_in[31:2], 2'b00};

    always_comb begin
        trap_target = (tvec_base == 32'h0) ? RESET_PC : tvec_base;
`ifdef YSYX_23060236_TRAP_VECTORED_EN
        if (mtvec_in[1:0] == 2'b01 && kind_q == K_IRQ)
            trap_target = trap_target + {25'b0, cause_q[4:0], 2'b00};
`endif
    end

`ifndef YSYX_23060236_TRAP_VECTORED_EN
    logic unused_tvec_mode;
    assign unused_tvec_mode = ^mtvec_in[1:0];
`endif

    // Trap entry stacks MIE into MPIE; mret restores it. MPP is always M-mode here.
    always_comb begin
        status_new        = mstatus_in;
        status_new[12:11] = 2'b11;
        if (kind_q == K_MRET) begin
            status_new[3] = mstatus_in[7];
            status_new[7] = 1'b1;
        end else begin
            status_new[7] = mstatus_in[3];
            status_new[3] = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        cause_d        = cause_q;
        save_pc_d      = save_pc_q;
        rpc_d          = rpc_q;
        csr_wen        = 1'b0;
        csr_waddr      = 12'h0;
        csr_wdata      = 32'h0;
        flush          = 1'b1;
        redirect_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                flush = 1'b0;
                if (exc_valid) begin
                    kind_d    = K_EXC;
                    cause_d   = {1'b0, exc_code};
                    save_pc_d = exc_pc;
                    state_d   = S_DRAIN;
                end else if (mret_valid) begin
                    kind_d    = K_MRET;
                    cause_d   = 6'h0;
                    save_pc_d = 32'h0;
                    state_d   = S_DRAIN;
                end else if (irq_take) begin
                    kind_d    = K_IRQ;
                    cause_d   = {1'b1, TIMER_CODE};
                    save_pc_d = irq_pc;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_idle)
                    state_d = (kind_q == K_MRET) ? S_WR_STATUS : S_WR_EPC;
            end
            S_WR_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = {save_pc_q[31:2], 2'b00};
                state_d   = S_WR_CAUSE;
            end
            S_WR_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = {cause_q[5], 26'b0, cause_q[4:0]};
                state_d   = S_WR_STATUS;
            end
            S_WR_STATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = status_new;
                // Target is frozen here so redirect_pc cannot move during backpressure.
                rpc_d     = (kind_q == K_MRET) ? mepc_in : trap_target;
                state_d   = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    rpc_d   = 32'h0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                flush   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign redirect_pc = rpc_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kind_q    <= K_EXC;
            cause_q   <= 6'h0;
            save_pc_q <= 32'h0;
            rpc_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cause_q   <= cause_d;
            save_pc_q <= save_pc_d;
            rpc_q     <= rpc_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_trap_ctrl.sv
// Self-checking bench for the trap sequencer: directed vector table, corner sequences, random traps.
module tb_ysyx_23060236_trap_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        exc_valid, mret_valid, irq_timer, pipe_idle, mie_mtie, redirect_ready;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, irq_pc, mstatus_in, mtvec_in, mepc_in;
    logic        csr_wen, flush, redirect_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;

    int total = 0;
    int bad   = 0;

    ysyx_23060236_trap_ctrl dut (
        .clock(clock), .reset(reset),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_valid(mret_valid), .irq_timer(irq_timer), .irq_pc(irq_pc),
        .pipe_idle(pipe_idle), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in),
        .mepc_in(mepc_in), .mie_mtie(mie_mtie),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string             nm;
        int                kind;      // 0 exception, 1 mret, 2 timer irq
        logic              irq_too;
        logic [4:0]        code;
        logic [31:0]       pc, ipc, ms, mtv, ep;
        int                idly, rdly;
        int                enw;
        logic [2:0][11:0]  ea;
        logic [2:0][31:0]  ed;
        logic [31:0]       erpc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input string what, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", nm, what, got, exp);
        end
    endtask

    // Reference: expected CSR write list and redirect target straight from the trap rules.
    function automatic void model(input int kind, input logic [4:0] code,
                                  input logic [31:0] pc, input logic [31:0] ipc,
                                  input logic [31:0] ms, input logic [31:0] mtv,
                                  input logic [31:0] ep, output int nw,
                                  output logic [2:0][11:0] a, output logic [2:0][31:0] d,
                                  output logic [31:0] rpc);
        logic [31:0] cause, st, base, bit_v;
        a = '0;
        d = '0;
        if (kind == 1) begin
            bit_v = (ms >> 7) & 32'h1;
            st    = (ms & ~32'h1888) | (bit_v << 3) | 32'h1880;
            nw    = 1;
            a[0]  = 12'h300;
            d[0]  = st;
            rpc   = ep;
        end else begin
            cause = (kind == 2) ? (32'h8000_0000 + 32'd7) : {27'b0, code};
            bit_v = (ms >> 3) & 32'h1;
            st    = (ms & ~32'h1888) | (bit_v << 7) | 32'h1800;
            nw    = 3;
            a[0]  = 12'h341; d[0] = ((kind == 2) ? ipc : pc) & ~32'h3;
            a[1]  = 12'h342; d[1] = cause;
            a[2]  = 12'h300; d[2] = st;
            base  = mtv & ~32'h3;
            rpc   = (base == 0) ? 32'h3000_0000 : base;
`ifdef YSYX_23060236_TRAP_VECTORED_EN
            if (kind == 2 && (mtv & 32'h3) == 32'h1) rpc = rpc + 4 * 7;
`endif
        end
    endfunction

    task automatic run_trap(input vec_t v);
        int n, lat, nwr, elat;
        logic fl_bad;
        logic [2:0][11:0] ga;
        logic [2:0][31:0] gd;
        ga = '0; gd = '0; nwr = 0; lat = -1; fl_bad = 1'b0;
        elat = ((v.kind == 1) ? 3 : 5) + v.idly;
        @(negedge clock);
        exc_code = v.code; exc_pc = v.pc; irq_pc = v.ipc;
        mstatus_in = v.ms; mtvec_in = v.mtv; mepc_in = v.ep;
        pipe_idle = (v.idly == 0); redirect_ready = 1'b0; mie_mtie = 1'b1;
        exc_valid  = (v.kind == 0);
        mret_valid = (v.kind == 1);
        irq_timer  = (v.kind == 2) || (v.kind == 0 && v.irq_too);
        @(negedge clock);
        exc_valid = 1'b0; mret_valid = 1'b0; irq_timer = 1'b0;
        n = 1;
        while (lat < 0 && n <= 40) begin
            pipe_idle = (n > v.idly);
            if (!flush) fl_bad = 1'b1;
            if (csr_wen) begin
                if (nwr < 3) begin ga[nwr] = csr_waddr; gd[nwr] = csr_wdata; end
                nwr++;
            end
            if (redirect_valid) lat = n;
            else begin n++; @(negedge clock); end
        end
        check(v.nm, "latency", lat, elat);
        check(v.nm, "flush_held", {31'b0, fl_bad}, 32'h0);
        check(v.nm, "n_writes", nwr, v.enw);
        for (int i = 0; i < v.enw && i < 3; i++) begin
            check(v.nm, "waddr", {20'b0, ga[i]}, {20'b0, v.ea[i]});
            check(v.nm, "wdata", gd[i], v.ed[i]);
        end
        check(v.nm, "redirect_pc", redirect_pc, v.erpc);
        for (int r = 0; r < v.rdly; r++) begin
            @(negedge clock);
            check(v.nm, "bp_valid", {31'b0, redirect_valid}, 32'h1);
            check(v.nm, "bp_pc", redirect_pc, v.erpc);
        end
        redirect_ready = 1'b1;
        @(negedge clock);
        redirect_ready = 1'b0;
        check(v.nm, "idle_after", {30'b0, busy, redirect_valid}, 32'h0);
    endtask

    function automatic vec_t mk(input string nm, input int kind, input logic irq_too,
                                input logic [4:0] code, input logic [31:0] pc, input logic [31:0] ipc,
                                input logic [31:0] ms, input logic [31:0] mtv, input logic [31:0] ep,
                                input int idly, input int rdly);
        vec_t v;
        v.nm = nm; v.kind = kind; v.irq_too = irq_too; v.code = code;
        v.pc = pc; v.ipc = ipc; v.ms = ms; v.mtv = mtv; v.ep = ep;
        v.idly = idly; v.rdly = rdly;
        v.enw = 0; v.ea = '0; v.ed = '0; v.erpc = 32'h0;
        return v;
    endfunction

    initial begin
        vec_t v;
        int nw;
        logic [2:0][11:0] a;
        logic [2:0][31:0] d;
        logic [31:0] rpc, vec_exp;
        reset = 1'b1;
        exc_valid = 0; mret_valid = 0; irq_timer = 0; pipe_idle = 1; mie_mtie = 0;
        redirect_ready = 0; exc_code = 0; exc_pc = 0; irq_pc = 0;
        mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
        repeat (3) @(negedge clock);
        check("reset", "outs", {28'b0, csr_wen, flush, redirect_valid, busy}, 32'h0);
        check("reset", "waddr_wdata_rpc", {20'b0, csr_waddr} | csr_wdata | redirect_pc, 32'h0);
        reset = 1'b0;

        // Directed vectors with hand-derived expectations.
`ifdef YSYX_23060236_TRAP_VECTORED_EN
        vec_exp = 32'h8000_021C;
`else
        vec_exp = 32'h8000_0200;
`endif
        vecs[0] = mk("ecall", 0, 0, 5'd11, 32'h8000_0104, 0, 32'h1808, 32'h8000_0200, 0, 0, 0);
        vecs[0].enw = 3; vecs[0].erpc = 32'h8000_0200;
        vecs[0].ea = {12'h300, 12'h342, 12'h341};
        vecs[0].ed = {32'h0000_1880, 32'h0000_000B, 32'h8000_0104};
        vecs[1] = mk("mret", 1, 0, 0, 0, 0, 32'h1880, 32'h8000_0200, 32'h8000_0108, 0, 0);
        vecs[1].enw = 1; vecs[1].erpc = 32'h8000_0108;
        vecs[1].ea = {12'h0, 12'h0, 12'h300}; vecs[1].ed = {32'h0, 32'h0, 32'h0000_1888};
        vecs[2] = mk("timer", 2, 0, 0, 0, 32'h8000_0040, 32'h0000_0008, 32'h8000_0200, 0, 0, 0);
        vecs[2].enw = 3; vecs[2].erpc = 32'h8000_0200;
        vecs[2].ea = {12'h300, 12'h342, 12'h341};
        vecs[2].ed = {32'h0000_1880, 32'h8000_0007, 32'h8000_0040};
        vecs[3] = mk("prio_bp", 0, 1, 5'd2, 32'h8000_0203, 32'h9000_0000, 32'h1808, 32'h0, 0, 4, 3);
        vecs[3].enw = 3; vecs[3].erpc = 32'h3000_0000;
        vecs[3].ea = {12'h300, 12'h342, 12'h341};
        vecs[3].ed = {32'h0000_1880, 32'h0000_0002, 32'h8000_0200};
        vecs[4] = mk("vectored", 2, 0, 0, 0, 32'h8000_0044, 32'h0000_0088, 32'h8000_0201, 0, 0, 1);
        vecs[4].enw = 3; vecs[4].erpc = vec_exp;
        vecs[4].ea = {12'h300, 12'h342, 12'h341};
        vecs[4].ed = {32'h0000_1880, 32'h8000_0007, 32'h8000_0044};
        vecs[5] = mk("mret_slow", 1, 0, 0, 0, 0, 32'h0000_0008, 32'h0, 32'h1234_5678, 2, 2);
        vecs[5].enw = 1; vecs[5].erpc = 32'h1234_5678;
        vecs[5].ea = {12'h0, 12'h0, 12'h300}; vecs[5].ed = {32'h0, 32'h0, 32'h0000_1880};
        for (int i = 0; i < 6; i++) run_trap(vecs[i]);

        // Timer pending but globally masked: must never be accepted.
        @(negedge clock);
        mstatus_in = 32'h0000_1880; irq_timer = 1'b1; mie_mtie = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin @(negedge clock); if (busy || flush) seen = 1'b1; end
            check("irq_masked", "busy", {31'b0, seen}, 32'h0);
        end
        irq_timer = 1'b0;

        // Async reset while mcause is being written.
        @(negedge clock);
        exc_valid = 1'b1; exc_code = 5'd11; exc_pc = 32'h8000_0100;
        mstatus_in = 32'h1808; mtvec_in = 32'h8000_0200; pipe_idle = 1'b1;
        @(negedge clock); exc_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_mid", "in_wr_cause", {20'b0, csr_waddr}, 32'h342);
        #1 reset = 1'b1;
        #1;
        check("rst_mid", "outs", {28'b0, csr_wen, flush, redirect_valid, busy}, 32'h0);
        check("rst_mid", "waddr_wdata", {20'b0, csr_waddr} | csr_wdata, 32'h0);
        @(negedge clock); reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (8) begin @(negedge clock); if (busy || redirect_valid || csr_wen) seen = 1'b1; end
            check("rst_mid", "quiet_after", {31'b0, seen}, 32'h0);
        end

        // Random traps against the reference model.
        for (int k = 0; k < 24; k++) begin
            v = mk("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)), 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) v.mtv = v.mtv & 32'h3;
            if (v.kind == 2) v.ms = v.ms | 32'h8;
            model(v.kind, v.code, v.pc, v.ipc, v.ms, v.mtv, v.ep, nw, a, d, rpc);
            v.enw = nw; v.ea = a; v.ed = d; v.erpc = rpc;
            run_trap(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
